// File: rtl/biu_prefetch_ctrl.sv
// 8088 min-mode bus interface: T1-T4 bus cycles with READY waits, code prefetch FIFO, word split.
// PREFETCH_EN selects read-ahead prefetch; left undefined, code is fetched on demand into a 1-byte FIFO.
module biu_prefetch_ctrl #(
   parameter int unsigned       QDEPTH   = 4,
   parameter int unsigned       ADDR_W   = 20,
   parameter logic [ADDR_W-1:0] RESET_PC = 20'hFFFF0,
   parameter int unsigned       PF_FREE  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ready,
   output logic              q_valid,
   output logic [7:0]        q_byte,
   input  logic              q_pop,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_adr,
   input  logic              dreq,
   input  logic              dwe,
   input  logic              dbyte,
   input  logic              dm_io,
   input  logic [ADDR_W-1:0] dadr,
   input  logic [15:0]       dwdat,
   output logic [15:0]       drdat,
   output logic              dack,
   output logic [ADDR_W-1:0] a,
   output logic [7:0]        ad_o,
   output logic              ad_oe,
   input  logic [7:0]        ad_i,
   output logic              ale,
   output logic              rd_n,
   output logic              wr_n,
   output logic              den_n,
   output logic              dtr,
   output logic              iom
);

`ifdef PREFETCH_EN
   localparam int unsigned DEPTH    = QDEPTH;
   localparam int unsigned MIN_FREE = PF_FREE;
`else
   // On-demand fetch: one slot, refilled only once it is empty.
   localparam int unsigned DEPTH    = (QDEPTH > 0) ? 1 : 1;
   localparam int unsigned MIN_FREE = (PF_FREE > 0) ? 1 : 1;
`endif

   typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4} state_t;

   state_t            state;
   logic              cyc_code;
   logic              cyc_drop;
   logic [ADDR_W-1:0] fetch_ptr;
   logic              d_we;
   logic              d_byte;
   logic              d_mio;
   logic              d_second;
   logic [ADDR_W-1:0] d_adr;
   logic [15:0]       d_wdat;
   logic [7:0]        d_lo;

   logic [7:0]        mem [16];
   logic [4:0]        count;
   logic [3:0]        rd_idx;
   logic [3:0]        wr_idx;

   logic              push;
   logic              pop;
   logic [4:0]        count_after;
   logic [ADDR_W-1:0] ptr_next;
   logic              at_edge;
   logic              rd_cycle;
   logic              data_last;
   logic              data_pend;
   logic              pf_ok;
   logic              start_second;
   logic              start_data;
   logic              start_code;
   logic [ADDR_W-1:0] nxt_adr;
   logic              nxt_we;
   logic              nxt_mio;
   logic [7:0]        wbyte;

   function automatic logic [3:0] idx_inc(input logic [3:0] i);
      return (i == 4'(DEPTH - 1)) ? 4'd0 : i + 4'd1;
   endfunction

   always_comb begin
      q_valid = (count != '0);
      q_byte  = mem[rd_idx];
   end

   always_comb begin
      rd_cycle    = cyc_code || !d_we;
      data_last   = d_byte || d_second;
      at_edge     = (state == S_IDLE) || (state == S_T4);
      push        = (state == S_T4) && cyc_code && !cyc_drop && !flush;
      pop         = q_pop && (count != '0);
      count_after = count + 5'(push) - 5'(pop);
      ptr_next    = push ? fetch_ptr + ADDR_W'(1) : fetch_ptr;
      // The access finishing in this T4 and the one just acked must not be restarted.
      data_pend   = dreq && !dack && !((state == S_T4) && !cyc_code && data_last);
      pf_ok       = !flush && ((5'(DEPTH) - count_after) >= 5'(MIN_FREE));
      start_second = (state == S_T4) && !cyc_code && !data_last;
      start_data   = at_edge && !start_second && data_pend;
      start_code   = at_edge && !start_second && !data_pend && pf_ok;
      wbyte        = d_second ? d_wdat[15:8] : d_wdat[7:0];
      nxt_adr = ptr_next;
      nxt_we  = 1'b0;
      nxt_mio = 1'b1;
      if (start_second) begin
         nxt_adr = d_adr + ADDR_W'(1);
         nxt_we  = d_we;
         nxt_mio = d_mio;
      end else if (start_data) begin
         nxt_adr = dadr;
         nxt_we  = dwe;
         nxt_mio = dm_io;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cyc_code  <= 1'b0;
         cyc_drop  <= 1'b0;
         fetch_ptr <= RESET_PC;
         d_we      <= 1'b0;
         d_byte    <= 1'b0;
         d_mio     <= 1'b0;
         d_second  <= 1'b0;
         d_adr     <= '0;
         d_wdat    <= '0;
         d_lo      <= '0;
         count     <= '0;
         rd_idx    <= '0;
         wr_idx    <= '0;
         ale       <= 1'b0;
         rd_n      <= 1'b1;
         wr_n      <= 1'b1;
         den_n     <= 1'b1;
         dtr       <= 1'b1;
         iom       <= 1'b0;
         ad_oe     <= 1'b0;
         ad_o      <= '0;
         a         <= '0;
         dack      <= 1'b0;
         drdat     <= '0;
      end else begin
         dack <= 1'b0;
         if (flush) begin
            count     <= '0;
            rd_idx    <= '0;
            wr_idx    <= '0;
            fetch_ptr <= flush_adr;
            if (cyc_code) cyc_drop <= 1'b1;
         end else begin
            if (push) begin
               mem[wr_idx] <= ad_i;
               wr_idx      <= idx_inc(wr_idx);
            end
            if (pop) rd_idx <= idx_inc(rd_idx);
            count     <= count_after;
            fetch_ptr <= ptr_next;
         end

         case (state)
            S_T1: begin
               state <= S_T2;
               ale   <= 1'b0;
               den_n <= 1'b0;
               if (rd_cycle) begin
                  rd_n  <= 1'b0;
                  ad_oe <= 1'b0;
               end else begin
                  wr_n  <= 1'b0;
                  ad_o  <= wbyte;
                  ad_oe <= 1'b1;
               end
            end
            S_T2: state <= S_T3;
            S_T3, S_TW: state <= ready ? S_T4 : S_TW;
            default: begin
               if ((state == S_T4) && !cyc_code) begin
                  if (!d_we) begin
                     if (d_byte)        drdat <= {8'h00, ad_i};
                     else if (d_second) drdat <= {ad_i, d_lo};
                     else               d_lo  <= ad_i;
                  end
                  if (data_last) dack <= 1'b1;
               end
               state <= S_IDLE;
               ale   <= 1'b0;
               rd_n  <= 1'b1;
               wr_n  <= 1'b1;
               den_n <= 1'b1;
               ad_oe <= 1'b0;
               if (start_second || start_data || start_code) begin
                  state    <= S_T1;
                  ale      <= 1'b1;
                  ad_oe    <= 1'b1;
                  a        <= nxt_adr;
                  ad_o     <= nxt_adr[7:0];
                  iom      <= ~nxt_mio;
                  dtr      <= nxt_we;
                  cyc_code <= start_code;
                  cyc_drop <= 1'b0;
               end
               if (start_second) d_second <= 1'b1;
               if (start_data) begin
                  d_we     <= dwe;
                  d_byte   <= dbyte;
                  d_mio    <= dm_io;
                  d_adr    <= dadr;
                  d_wdat   <= dwdat;
                  d_second <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule
